// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer
// Captures one batch of colour values from the LUT array and streams it out one
// pixel per beat on a valid/ready interface. Keeps the raster position across
// batches and flags start-of-frame, end-of-line and frame completion.

module pixel_stream_packer #(
  parameter int RGB_SIZE    = 24,
  parameter int NUM_ENGINES = 30,
  parameter int IMAGE_W     = 640,
  parameter int IMAGE_H     = 480,
  parameter int COORD_WIDTH = 11,
  parameter int CNT_WIDTH   = $clog2(NUM_ENGINES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   batch_valid,
  output logic                   batch_ready,
  input  logic [RGB_SIZE-1:0]    rgb_in [NUM_ENGINES-1:0],
  input  logic [CNT_WIDTH-1:0]   batch_count,
  output logic [RGB_SIZE-1:0]    out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic [COORD_WIDTH-1:0] x_pos,
  output logic [COORD_WIDTH-1:0] y_pos,
  output logic                   frame_done
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [CNT_WIDTH-1:0]   CNT_MAX = CNT_WIDTH'(NUM_ENGINES);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [COORD_WIDTH-1:0] X_LAST  = COORD_WIDTH'(IMAGE_W - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST  = COORD_WIDTH'(IMAGE_H - 1);
  localparam logic [COORD_WIDTH-1:0] C_ZERO  = COORD_WIDTH'(0);
  localparam logic [COORD_WIDTH-1:0] C_ONE   = COORD_WIDTH'(1);

  // Registered state
  logic [0:0]             state_q, state_d;
  logic [RGB_SIZE-1:0]    buf_q [NUM_ENGINES-1:0];
  logic [CNT_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   last_q, last_d;
  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic [RGB_SIZE-1:0]    data_q, data_d;
  logic                   done_q, done_d;

  // Combinational helpers
  logic                   accept_s;
  logic                   take_s;
  logic [CNT_WIDTH-1:0]   clamp_s;
  logic                   beat_s;
  logic                   last_beat_s;
  logic                   frame_end_s;
  logic [CNT_WIDTH-1:0]   idx_nxt_s;

  // Handshake decode and count clamping; a zero-count batch is consumed but never streamed.
  always_comb begin
    accept_s    = (state_q == ST_IDLE) && batch_valid;
    if (batch_count > CNT_MAX) begin
      clamp_s = CNT_MAX;
    end else begin
      clamp_s = batch_count;
    end
    take_s      = accept_s && (clamp_s != CNT_ZERO);
    beat_s      = (state_q == ST_STREAM) && out_ready;
    last_beat_s = beat_s && (idx_q == last_q);
    frame_end_s = beat_s && (x_q == X_LAST) && (y_q == Y_LAST);
    idx_nxt_s   = idx_q + CNT_ONE;
  end

  // Next-state logic for the FSM, buffer index and the output data register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d = ST_STREAM;
          idx_d   = CNT_ZERO;
          last_d  = clamp_s - CNT_ONE;
          data_d  = rgb_in[0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_beat_s) begin
          state_d = ST_IDLE;
        end else if (beat_s) begin
          idx_d  = idx_nxt_s;
          // idx_nxt_s is only in range when this was not the last entry
          data_d = buf_q[idx_nxt_s];
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Raster position: advance one pixel per transferred beat, wrap at line and frame ends.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    done_d = frame_end_s;
    if (beat_s) begin
      if (x_q == X_LAST) begin
        x_d = C_ZERO;
        if (y_q == Y_LAST) begin
          y_d = C_ZERO;
        end else begin
          y_d = y_q + C_ONE;
        end
      end else begin
        x_d = x_q + C_ONE;
      end
    end else begin
      x_d = x_q;
    end
  end

  // All state updates; reset drops any buffered batch and returns to the origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= CNT_ZERO;
      last_q  <= CNT_ZERO;
      x_q     <= C_ZERO;
      y_q     <= C_ZERO;
      data_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      done_q  <= done_d;
      if (take_s) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
          buf_q[i] <= rgb_in[i];
        end
      end
    end
  end

  // Outputs are driven straight from registers; sof/eol are qualified by valid so they read 0 when idle.
  always_comb begin
    out_valid   = (state_q == ST_STREAM);
    batch_ready = (state_q == ST_IDLE);
    out_data    = data_q;
    x_pos       = x_q;
    y_pos       = y_q;
    frame_done  = done_q;
    out_sof     = out_valid && (x_q == C_ZERO) && (y_q == C_ZERO);
    out_eol     = out_valid && (x_q == X_LAST);
  end

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed testbench for pixel_stream_packer with a 4x2 image and 3-entry batches.

module tb_pixel_stream_packer;

  logic        clk;
  logic        rst;
  logic        batch_valid;
  logic        batch_ready;
  logic [23:0] rgb_in [2:0];
  logic [2:0]  batch_count;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic        frame_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  pixel_stream_packer #(
    .RGB_SIZE(24), .NUM_ENGINES(3), .IMAGE_W(4), .IMAGE_H(2),
    .COORD_WIDTH(11), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .batch_valid(batch_valid), .batch_ready(batch_ready),
    .rgb_in(rgb_in), .batch_count(batch_count), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eol(out_eol), .x_pos(x_pos), .y_pos(y_pos), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a batch once the packer is ready, hold it for one edge, then withdraw it.
  task automatic accept(input logic [23:0] d0, input logic [23:0] d1,
                        input logic [23:0] d2, input logic [2:0] cnt);
    int n;
    n = 0;
    while (batch_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'd0, batch_ready}, 32'd1);
    rgb_in[0]   = d0;
    rgb_in[1]   = d1;
    rgb_in[2]   = d2;
    batch_count = cnt;
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
  endtask

  // Check the beat currently on the output, then let it transfer.
  task automatic beat(input string tag, input logic [23:0] d, input int x, input int y,
                      input logic sof, input logic eol);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  {8'd0, out_data}, {8'd0, d});
    chk({tag, "_x"},     {21'd0, x_pos}, x);
    chk({tag, "_y"},     {21'd0, y_pos}, y);
    chk({tag, "_sof"},   {31'd0, out_sof}, {31'd0, sof});
    chk({tag, "_eol"},   {31'd0, out_eol}, {31'd0, eol});
    chk({tag, "_bready"}, {31'd0, batch_ready}, 32'd0);
    chk({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    batch_valid = 1'b0;
    batch_count = 3'd0;
    out_ready = 1'b1;
    rgb_in[0] = 24'd0;
    rgb_in[1] = 24'd0;
    rgb_in[2] = 24'd0;

    // 1: reset
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_x", {21'd0, x_pos}, 32'd0);
    chk("rst_y", {21'd0, y_pos}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    chk("rst_bready", {31'd0, batch_ready}, 32'd1);
    chk("rst_sof", {31'd0, out_sof}, 32'd0);
    rst = 1'b0;
    tick();

    // 2: basic batch, beats in entry order
    accept(24'h0000FF, 24'h00FF00, 24'hFF0000, 3'd3);
    beat("t2b1", 24'h0000FF, 0, 0, 1'b1, 1'b0);
    beat("t2b2", 24'h00FF00, 1, 0, 1'b0, 1'b0);
    beat("t2b3", 24'hFF0000, 2, 0, 1'b0, 1'b0);
    chk("t2_bready_after", {31'd0, batch_ready}, 32'd1);
    chk("t2_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t2_x_after", {21'd0, x_pos}, 32'd3);

    // 3: backpressure on beat 2 (position continues from x=3,y=0)
    accept(24'h0000FF, 24'h00FF00, 24'hFF0000, 3'd3);
    beat("t3b1", 24'h0000FF, 3, 0, 1'b0, 1'b1);
    out_ready = 1'b0;
    tick();
    chk("t3_stall1_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_stall1_data", {8'd0, out_data}, 32'h0000FF00);
    chk("t3_stall1_x", {21'd0, x_pos}, 32'd0);
    chk("t3_stall1_y", {21'd0, y_pos}, 32'd1);
    tick();
    chk("t3_stall2_data", {8'd0, out_data}, 32'h0000FF00);
    chk("t3_stall2_x", {21'd0, x_pos}, 32'd0);
    beat("t3b2", 24'h00FF00, 0, 1, 1'b0, 1'b0);
    beat("t3b3", 24'hFF0000, 1, 1, 1'b0, 1'b0);
    chk("t3_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t3_x_after", {21'd0, x_pos}, 32'd2);

    // return to the origin for the frame-wrap test
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_pre_x", {21'd0, x_pos}, 32'd0);
    chk("t4_pre_y", {21'd0, y_pos}, 32'd0);

    // 4: line and frame wrap over batches of 3,3,2
    accept(24'h000001, 24'h000002, 24'h000003, 3'd3);
    beat("t4p1", 24'h000001, 0, 0, 1'b1, 1'b0);
    beat("t4p2", 24'h000002, 1, 0, 1'b0, 1'b0);
    beat("t4p3", 24'h000003, 2, 0, 1'b0, 1'b0);
    accept(24'h000004, 24'h000005, 24'h000006, 3'd3);
    beat("t4p4", 24'h000004, 3, 0, 1'b0, 1'b1);
    beat("t4p5", 24'h000005, 0, 1, 1'b0, 1'b0);
    beat("t4p6", 24'h000006, 1, 1, 1'b0, 1'b0);
    accept(24'h000007, 24'h000008, 24'h0000EE, 3'd2);
    beat("t4p7", 24'h000007, 2, 1, 1'b0, 1'b0);
    beat("t4p8", 24'h000008, 3, 1, 1'b0, 1'b1);
    chk("t4_fdone_pulse", {31'd0, frame_done}, 32'd1);
    chk("t4_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t4_x_wrap", {21'd0, x_pos}, 32'd0);
    chk("t4_y_wrap", {21'd0, y_pos}, 32'd0);
    tick();
    chk("t4_fdone_clear", {31'd0, frame_done}, 32'd0);
    accept(24'h0000AA, 24'h0000BB, 24'h0000CC, 3'd1);
    beat("t4next", 24'h0000AA, 0, 0, 1'b1, 1'b0);
    chk("t4next_valid_after", {31'd0, out_valid}, 32'd0);

    // 5: count 0 is dropped, count 5 clamps to 3 (position now x=1,y=0)
    accept(24'h123456, 24'h234567, 24'h345678, 3'd0);
    chk("t5_zero_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_zero_bready", {31'd0, batch_ready}, 32'd1);
    tick();
    chk("t5_zero_valid2", {31'd0, out_valid}, 32'd0);
    chk("t5_zero_x", {21'd0, x_pos}, 32'd1);
    accept(24'h111111, 24'h222222, 24'h333333, 3'd5);
    beat("t5c1", 24'h111111, 1, 0, 1'b0, 1'b0);
    beat("t5c2", 24'h222222, 2, 0, 1'b0, 1'b0);
    beat("t5c3", 24'h333333, 3, 0, 1'b0, 1'b1);
    chk("t5_clamp_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t5_clamp_y_after", {21'd0, y_pos}, 32'd1);

    // 6: reset mid-batch discards the rest and restarts at the origin
    accept(24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 3'd3);
    beat("t6b1", 24'h0A0A0A, 0, 1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_x", {21'd0, x_pos}, 32'd0);
    chk("t6_rst_y", {21'd0, y_pos}, 32'd0);
    chk("t6_rst_bready", {31'd0, batch_ready}, 32'd1);
    accept(24'h0D0D0D, 24'h0E0E0E, 24'h0F0F0F, 3'd3);
    beat("t6n1", 24'h0D0D0D, 0, 0, 1'b1, 1'b0);
    beat("t6n2", 24'h0E0E0E, 1, 0, 1'b0, 1'b0);
    beat("t6n3", 24'h0F0F0F, 2, 0, 1'b0, 1'b0);
    chk("t6_valid_after", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
